mtpsa_tuple_bridge: RTL and testbench
=====================================

Name: mtpsa_tuple_bridge

Overview:
Parametrised replacement for the SUME<->SDNet tuple glue in the MTPSA wrappers. Ingress side: tracks packet boundaries and pulses the engine's tuple-valid on each first accepted beat. Egress side: buffers one metadata+digest tuple per packet in a FIFO and drives m_axis_tuser, stable for the whole output packet, so tuple timing is decoupled from packet_out timing. Sits between the nf_sdnet_* AXIS ports and the SDNet engine, for any user count and digest width.

Parameters:
KEEP_WIDTH, 48, low tuple bits passed through (pkt_len, ports, user_id, send_dig)
S_TUSER_WIDTH, 128, engine metadata tuple width
DIGEST_WIDTH, 256, engine digest tuple width
TUPLE_FIFO_DEPTH, 4, tuple buffer entries, power of two, >=2
NUM_USERS, 4, MTPSA user count for stats, <=256
M_TUSER_WIDTH, DIGEST_WIDTH+KEEP_WIDTH, derived, not overridable

Ports:
axis_aclk  in  1  single clock
axis_rst  in  1  synchronous, active-high reset
s_axis_tvalid  in  1  SUME ingress valid
s_axis_tready  in  1  engine packet_in ready (observed only)
s_axis_tlast  in  1  SUME ingress last
sdnet_tuple_in_valid  out  1  one-cycle SOP pulse to engine
sdnet_in_tlast  out  1  qualified last to engine
eng_tuple_valid  in  1  engine metadata tuple valid
eng_tuple_data  in  S_TUSER_WIDTH  engine metadata tuple
eng_digest_valid  in  1  engine digest valid
eng_digest_data  in  DIGEST_WIDTH  engine digest
eng_out_tvalid  in  1  engine packet_out valid
eng_out_tready  out  1  ready to engine packet_out
eng_out_tlast  in  1  engine packet_out last
m_axis_tvalid  out  1  egress valid
m_axis_tready  in  1  egress ready
m_axis_tuser  out  M_TUSER_WIDTH  {digest, tuple[KEEP_WIDTH-1:0]}
tuple_ovf  out  1  sticky: tuple dropped on full FIFO
stat_user  in  8  stats read index
stat_count  out  32  stats read data

Behaviour:
- Reset: ingress FSM IDLE; FIFO empty; sdnet_tuple_in_valid=0, m_axis_tvalid=0, eng_out_tready=0, m_axis_tuser=0, tuple_ovf=0, stat_count=0.
- Ingress FSM, in_xfer = s_axis_tvalid & s_axis_tready:
  - IDLE: in_xfer & !tlast -> IN_PKT; in_xfer & tlast (1-beat packet) stays IDLE.
  - IN_PKT: in_xfer & tlast -> IDLE.
  - sdnet_tuple_in_valid = (state==IDLE) & s_axis_tvalid, combinational; it holds while stalled on tready.
  - sdnet_in_tlast = s_axis_tlast & s_axis_tvalid.
- Tuple push on eng_tuple_valid. Entry = {eng_digest_valid ? eng_digest_data : 0, eng_tuple_data[KEEP_WIDTH-1:0]}. eng_digest_valid without eng_tuple_valid is ignored.
- Push while full (and no pop that cycle) drops the entry and sets tuple_ovf, cleared only by reset. Push and pop in the same cycle while full: both happen, no overflow.
- Egress:
  - m_axis_tvalid = eng_out_tvalid & !empty.
  - eng_out_tready = m_axis_tready & !empty.
  - m_axis_tuser = FIFO head, registered output, constant across every beat of a packet.
  - Pop on m_axis_tvalid & m_axis_tready & eng_out_tlast.
- Latency: no bypass. A tuple pushed at cycle t is at the head and can qualify m_axis_tvalid at t+1, including the empty-FIFO case.
- Pointers are log2(DEPTH)+1 bits with natural wrap. Full = MSBs differ and rest equal.
- Mid-packet reset: FIFO flushed, FSM IDLE; the remaining beats of the interrupted output are held off (FIFO empty) until the next tuple arrives.

Optional Feature:
MTPSA_USER_STATS_EN:
- Defined: NUM_USERS 32-bit counters; counter[user_id] increments on each pop, where user_id = popped tuple bits [39:32]. Counters wrap at 2^32. user_id >= NUM_USERS increments nothing.
- stat_count = counter[stat_user], registered, 1-cycle read latency; out-of-range stat_user returns 0. Counters clear on reset.
- Undefined: no counters are built, stat_count is tied to 0, stat_user is unused.

Decomposition:
- Shared package mtpsa_pkg: tuser field offsets (PKT_LEN 15:0, SRC 23:16, DST 31:24, USER_ID 39:32, SEND_DIG 47:40), KEEP_WIDTH default, tuple entry struct typedef, FSM state enum.
- One sub-module: mtpsa_tuple_fifo (synchronous FIFO, push/pop/full/empty/head).

Test Plan:
- 1-beat packet (tvalid&tready&tlast at cycle 0) -> sdnet_tuple_in_valid=1 at cycle 0, FSM stays IDLE; a second packet at cycle 1 also pulses.
- 3-beat packet with tready low at beats 0 and 2 -> tuple_in_valid held high only until beat 0 is accepted; sdnet_in_tlast high only on beat 2.
- Tuple user_id=2, digest=0xABCD, then 4-beat output -> m_axis_tuser[63:48]=0xABCD and [39:32]=2 on all 4 beats; FIFO empty after the last handshake.
- Tuple without eng_digest_valid -> digest field 0; output tvalid withheld while the FIFO is empty, even when eng_out_tvalid=1.
- DEPTH=4: 5 tuples, no pops -> tuple_ovf=1, first 4 output in order; 4 tuples plus simultaneous push/pop -> tuple_ovf stays 0.
- Stats build: 3 packets user 1, 2 packets user 3 -> stat_user=1 reads 3, stat_user=3 reads 2, stat_user=9 reads 0.

Source files
------------

// File: rtl/mtpsa_pkg.sv
// mtpsa_pkg: shared tuple field offsets, entry layout and ingress FSM states
package mtpsa_pkg;
  localparam int KEEP_WIDTH_DEF = 48;
  localparam int PKT_LEN_LSB = 0, PKT_LEN_MSB = 15;
  localparam int SRC_LSB = 16, SRC_MSB = 23;
  localparam int DST_LSB = 24, DST_MSB = 31;
  localparam int USER_ID_LSB = 32, USER_ID_MSB = 39;
  localparam int SEND_DIG_LSB = 40, SEND_DIG_MSB = 47;
  typedef struct packed {
    logic [255:0] digest;
    logic [KEEP_WIDTH_DEF-1:0] keep;
  } tuple_entry_t;
  typedef enum logic {IDLE, IN_PKT} in_state_e;
endpackage

// File: rtl/mtpsa_tuple_fifo.sv
// mtpsa_tuple_fifo: synchronous tuple FIFO with a registered head that is valid the cycle after a push
module mtpsa_tuple_fifo #(
  parameter int W = 304,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr, rd, rd_n;
  logic do_push, do_pop;
  assign empty = wr == rd;
  assign full = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_n = rd + {{AW{1'b0}}, do_pop};
  // head is preloaded from the next read slot, or from din when that slot is being written now
  always_ff @(posedge clk) begin
    if (rst) begin
      wr <= '0;
      rd <= '0;
      head <= '0;
    end else begin
      if (do_push) begin
        mem[wr[AW-1:0]] <= din;
        wr <= wr + 1'b1;
      end
      rd <= rd_n;
      head <= (do_push && wr == rd_n) ? din : mem[rd_n[AW-1:0]];
    end
  end
endmodule

// File: rtl/mtpsa_tuple_bridge.sv
// mtpsa_tuple_bridge: SUME<->SDNet tuple glue; per-user pop counters under MTPSA_USER_STATS_EN
module mtpsa_tuple_bridge import mtpsa_pkg::*; #(
  parameter int KEEP_WIDTH = KEEP_WIDTH_DEF,
  parameter int S_TUSER_WIDTH = 128,
  parameter int DIGEST_WIDTH = 256,
  parameter int TUPLE_FIFO_DEPTH = 4,
  parameter int NUM_USERS = 4,
  localparam int M_TUSER_WIDTH = DIGEST_WIDTH + KEEP_WIDTH
) (
  input  logic                     axis_aclk,
  input  logic                     axis_rst,
  input  logic                     s_axis_tvalid,
  input  logic                     s_axis_tready,
  input  logic                     s_axis_tlast,
  output logic                     sdnet_tuple_in_valid,
  output logic                     sdnet_in_tlast,
  input  logic                     eng_tuple_valid,
  input  logic [S_TUSER_WIDTH-1:0] eng_tuple_data,
  input  logic                     eng_digest_valid,
  input  logic [DIGEST_WIDTH-1:0]  eng_digest_data,
  input  logic                     eng_out_tvalid,
  output logic                     eng_out_tready,
  input  logic                     eng_out_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [M_TUSER_WIDTH-1:0] m_axis_tuser,
  output logic                     tuple_ovf,
  input  logic [7:0]               stat_user,
  output logic [31:0]              stat_count
);
  in_state_e state, state_n;
  logic in_xfer, full, empty, pop;
  logic [M_TUSER_WIDTH-1:0] entry;
  logic unused_tuple;
  assign in_xfer = s_axis_tvalid && s_axis_tready;
  always_ff @(posedge axis_aclk) state <= axis_rst ? IDLE : state_n;
  always_comb begin
    state_n = in_xfer ? (s_axis_tlast ? IDLE : IN_PKT) : state;
    sdnet_tuple_in_valid = (state == IDLE) && s_axis_tvalid;
    sdnet_in_tlast = s_axis_tlast && s_axis_tvalid;
  end
  assign entry = {eng_digest_valid ? eng_digest_data : {DIGEST_WIDTH{1'b0}}, eng_tuple_data[KEEP_WIDTH-1:0]};
  assign unused_tuple = ^eng_tuple_data[S_TUSER_WIDTH-1:KEEP_WIDTH];
  assign m_axis_tvalid = eng_out_tvalid && !empty;
  assign eng_out_tready = m_axis_tready && !empty;
  assign pop = m_axis_tvalid && m_axis_tready && eng_out_tlast;
  mtpsa_tuple_fifo #(.W(M_TUSER_WIDTH), .DEPTH(TUPLE_FIFO_DEPTH)) u_fifo (
    .clk(axis_aclk),
    .rst(axis_rst),
    .push(eng_tuple_valid),
    .pop(pop),
    .din(entry),
    .full(full),
    .empty(empty),
    .head(m_axis_tuser)
  );
  always_ff @(posedge axis_aclk) begin
    if (axis_rst) tuple_ovf <= 1'b0;
    else if (eng_tuple_valid && full && !pop) tuple_ovf <= 1'b1;
  end
`ifdef MTPSA_USER_STATS_EN
  logic [31:0] cnt [NUM_USERS];
  logic [31:0] rd_val;
  logic [7:0] uid;
  assign uid = m_axis_tuser[USER_ID_MSB:USER_ID_LSB];
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_USERS; i++) if (int'(stat_user) == i) rd_val = cnt[i];
  end
  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      for (int i = 0; i < NUM_USERS; i++) cnt[i] <= '0;
      stat_count <= '0;
    end else begin
      for (int i = 0; i < NUM_USERS; i++) if (pop && int'(uid) == i) cnt[i] <= cnt[i] + 32'd1;
      stat_count <= rd_val;
    end
  end
`else
  logic unused_stat;
  assign unused_stat = ^stat_user;
  assign stat_count = '0;
`endif
endmodule

// File: tb/tb_mtpsa_tuple_bridge.sv
// tb_mtpsa_tuple_bridge: directed and randomized checks against a queue-based tuple model
module tb_mtpsa_tuple_bridge;
  localparam int KW = 48, SW = 128, DW = 256, D = 4, NU = 4, MW = DW + KW;
  logic clk = 0, rst = 0;
  logic s_axis_tvalid, s_axis_tready, s_axis_tlast, sdnet_tuple_in_valid, sdnet_in_tlast;
  logic eng_tuple_valid, eng_digest_valid, eng_out_tvalid, eng_out_tready, eng_out_tlast;
  logic m_axis_tvalid, m_axis_tready, tuple_ovf;
  logic [SW-1:0] eng_tuple_data;
  logic [DW-1:0] eng_digest_data;
  logic [MW-1:0] m_axis_tuser;
  logic [7:0] stat_user;
  logic [31:0] stat_count;
  int n_checks = 0, n_fail = 0;
  logic [MW-1:0] q[$];
  bit m_inpkt, m_ovf;
  int unsigned m_cnt[NU];
  logic [31:0] exp_stat;

  always #5 clk = ~clk;

  mtpsa_tuple_bridge #(.KEEP_WIDTH(KW), .S_TUSER_WIDTH(SW), .DIGEST_WIDTH(DW),
    .TUPLE_FIFO_DEPTH(D), .NUM_USERS(NU)) dut (
    .axis_aclk(clk), .axis_rst(rst),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .sdnet_tuple_in_valid(sdnet_tuple_in_valid), .sdnet_in_tlast(sdnet_in_tlast),
    .eng_tuple_valid(eng_tuple_valid), .eng_tuple_data(eng_tuple_data),
    .eng_digest_valid(eng_digest_valid), .eng_digest_data(eng_digest_data),
    .eng_out_tvalid(eng_out_tvalid), .eng_out_tready(eng_out_tready), .eng_out_tlast(eng_out_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tuser(m_axis_tuser),
    .tuple_ovf(tuple_ovf), .stat_user(stat_user), .stat_count(stat_count));

  function automatic void model_reset();
    q.delete();
    m_inpkt = 0;
    m_ovf = 0;
    for (int i = 0; i < NU; i++) m_cnt[i] = 0;
    exp_stat = 0;
  endfunction

  // Advances the model by one clock using the inputs currently driven
  function automatic void model_step();
    bit pop;
    int uid;
    if (rst) begin
      model_reset();
      return;
    end
    pop = eng_out_tvalid && q.size() > 0 && m_axis_tready && eng_out_tlast;
    if (s_axis_tvalid && s_axis_tready) m_inpkt = !s_axis_tlast;
`ifdef MTPSA_USER_STATS_EN
    exp_stat = (stat_user < NU) ? m_cnt[stat_user] : 0;
`else
    exp_stat = 0;
`endif
    if (pop) begin
      uid = int'(q[0][39:32]);
      if (uid < NU) m_cnt[uid]++;
      void'(q.pop_front());
    end
    if (eng_tuple_valid) begin
      if (q.size() < D) q.push_back({eng_digest_valid ? eng_digest_data : {DW{1'b0}}, eng_tuple_data[KW-1:0]});
      else m_ovf = 1;
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s_axis_tvalid = 0; s_axis_tready = 0; s_axis_tlast = 0;
    eng_tuple_valid = 0; eng_digest_valid = 0; eng_tuple_data = '0; eng_digest_data = '0;
    eng_out_tvalid = 0; eng_out_tlast = 0; m_axis_tready = 0; stat_user = 0;
  endtask

  function automatic logic [SW-1:0] rand_tuple(input logic [7:0] uid);
    logic [SW-1:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    t[39:32] = uid;
    return t;
  endfunction

  function automatic logic [DW-1:0] rand_digest();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic do_reset();
    rst = 1; idle(); tick(); tick(); rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    eng_out_tvalid = 1; m_axis_tready = 1; #1;
    n_checks++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid got %b exp 0", m_axis_tvalid); end
    n_checks++; if (eng_out_tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready got %b exp 0", eng_out_tready); end
    n_checks++; if (m_axis_tuser !== '0) begin n_fail++; $display("FAIL reset_tuser got %h exp 0", m_axis_tuser); end
    n_checks++; if (tuple_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", tuple_ovf); end
    n_checks++; if (stat_count !== 32'd0) begin n_fail++; $display("FAIL reset_stat got %0d exp 0", stat_count); end
    n_checks++; if (sdnet_tuple_in_valid !== 1'b0) begin n_fail++; $display("FAIL reset_sop got %b exp 0", sdnet_tuple_in_valid); end
    tick(); idle();
  endtask

  task automatic test_one_beat();
    s_axis_tvalid = 1; s_axis_tready = 1; s_axis_tlast = 1; #1;
    n_checks++; if (sdnet_tuple_in_valid !== 1'b1) begin n_fail++; $display("FAIL one_beat_sop0 got %b exp 1", sdnet_tuple_in_valid); end
    n_checks++; if (sdnet_in_tlast !== 1'b1) begin n_fail++; $display("FAIL one_beat_last0 got %b exp 1", sdnet_in_tlast); end
    tick(); #1;
    n_checks++; if (sdnet_tuple_in_valid !== 1'b1) begin n_fail++; $display("FAIL one_beat_sop1 got %b exp 1", sdnet_tuple_in_valid); end
    tick(); idle();
  endtask

  task automatic test_stall();
    bit exp_sop[5] = '{1, 1, 0, 0, 0};
    bit exp_last[5] = '{0, 0, 0, 1, 1};
    bit rdy[5] = '{0, 1, 1, 0, 1};
    bit lst[5] = '{0, 0, 0, 1, 1};
    for (int i = 0; i < 5; i++) begin
      s_axis_tvalid = 1; s_axis_tready = rdy[i]; s_axis_tlast = lst[i]; #1;
      n_checks++; if (sdnet_tuple_in_valid !== exp_sop[i]) begin n_fail++; $display("FAIL stall_sop[%0d] got %b exp %b", i, sdnet_tuple_in_valid, exp_sop[i]); end
      n_checks++; if (sdnet_in_tlast !== exp_last[i]) begin n_fail++; $display("FAIL stall_last[%0d] got %b exp %b", i, sdnet_in_tlast, exp_last[i]); end
      tick();
    end
    idle(); #1;
    s_axis_tvalid = 1; #1;
    n_checks++; if (sdnet_tuple_in_valid !== 1'b1) begin n_fail++; $display("FAIL stall_idle_after got %b exp 1", sdnet_tuple_in_valid); end
    idle();
  endtask

  task automatic test_digest();
    eng_tuple_valid = 1; eng_tuple_data = rand_tuple(8'd2);
    eng_digest_valid = 1; eng_digest_data = {{(DW-16){1'b0}}, 16'hABCD};
    tick(); idle();
    for (int b = 0; b < 4; b++) begin
      eng_out_tvalid = 1; m_axis_tready = 1; eng_out_tlast = (b == 3); #1;
      n_checks++; if (m_axis_tvalid !== 1'b1) begin n_fail++; $display("FAIL digest_tvalid[%0d] got %b exp 1", b, m_axis_tvalid); end
      n_checks++; if (m_axis_tuser[63:48] !== 16'hABCD) begin n_fail++; $display("FAIL digest_field[%0d] got %h exp abcd", b, m_axis_tuser[63:48]); end
      n_checks++; if (m_axis_tuser[39:32] !== 8'd2) begin n_fail++; $display("FAIL digest_uid[%0d] got %0d exp 2", b, m_axis_tuser[39:32]); end
      tick();
    end
    eng_out_tlast = 0; #1;
    n_checks++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL digest_empty got %b exp 0", m_axis_tvalid); end
    idle();
  endtask

  task automatic test_no_digest();
    eng_out_tvalid = 1; m_axis_tready = 1; #1;
    n_checks++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL nodig_withheld got %b exp 0", m_axis_tvalid); end
    eng_out_tvalid = 0;
    eng_tuple_valid = 1; eng_tuple_data = rand_tuple(8'd1); eng_digest_valid = 0; eng_digest_data = rand_digest() | 1;
    tick(); idle();
    eng_out_tvalid = 1; m_axis_tready = 1; eng_out_tlast = 1; #1;
    n_checks++; if (m_axis_tvalid !== 1'b1) begin n_fail++; $display("FAIL nodig_tvalid got %b exp 1", m_axis_tvalid); end
    n_checks++; if (m_axis_tuser[MW-1:KW] !== '0) begin n_fail++; $display("FAIL nodig_field got %h exp 0", m_axis_tuser[MW-1:KW]); end
    tick(); idle();
    eng_digest_valid = 1; eng_digest_data = rand_digest(); tick(); idle();
    eng_out_tvalid = 1; #1;
    n_checks++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL nodig_lone_digest got %b exp 0", m_axis_tvalid); end
    idle();
  endtask

  task automatic test_overflow();
    logic [MW-1:0] lst[5];
    do_reset();
    for (int i = 0; i < 5; i++) begin
      eng_tuple_valid = 1; eng_tuple_data = rand_tuple(8'(i)); eng_digest_valid = 1; eng_digest_data = rand_digest();
      lst[i] = {eng_digest_data, eng_tuple_data[KW-1:0]};
      tick();
      if (i == 3) begin
        n_checks++; if (tuple_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_at4 got %b exp 0", tuple_ovf); end
      end
    end
    idle(); #1;
    n_checks++; if (tuple_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_at5 got %b exp 1", tuple_ovf); end
    for (int i = 0; i < 4; i++) begin
      eng_out_tvalid = 1; m_axis_tready = 1; eng_out_tlast = 1; #1;
      n_checks++; if (m_axis_tuser !== lst[i]) begin n_fail++; $display("FAIL ovf_order[%0d] got %h exp %h", i, m_axis_tuser, lst[i]); end
      tick();
    end
    #1;
    n_checks++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained got %b exp 0", m_axis_tvalid); end
    idle(); do_reset();
    for (int i = 0; i < 5; i++) begin
      eng_tuple_valid = 1; eng_tuple_data = rand_tuple(8'(i)); eng_digest_valid = 0;
      lst[i] = {{DW{1'b0}}, eng_tuple_data[KW-1:0]};
      eng_out_tvalid = (i == 4); m_axis_tready = (i == 4); eng_out_tlast = (i == 4);
      tick();
    end
    idle(); #1;
    n_checks++; if (tuple_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_pushpop got %b exp 0", tuple_ovf); end
    for (int i = 1; i < 5; i++) begin
      eng_out_tvalid = 1; m_axis_tready = 1; eng_out_tlast = 1; #1;
      n_checks++; if (m_axis_tuser !== lst[i]) begin n_fail++; $display("FAIL pushpop_order[%0d] got %h exp %h", i, m_axis_tuser, lst[i]); end
      tick();
    end
    idle();
  endtask

  task automatic test_stats();
    logic [7:0] uids[5] = '{1, 3, 1, 3, 1};
    int users[3] = '{1, 3, 9};
    int exp_c[3];
`ifdef MTPSA_USER_STATS_EN
    exp_c = '{3, 2, 0};
`else
    exp_c = '{0, 0, 0};
`endif
    do_reset();
    for (int i = 0; i < 5; i++) begin
      eng_tuple_valid = 1; eng_tuple_data = rand_tuple(uids[i]); tick(); idle();
      eng_out_tvalid = 1; m_axis_tready = 1; eng_out_tlast = 1; tick(); idle();
    end
    for (int i = 0; i < 3; i++) begin
      stat_user = 8'(users[i]); tick();
      n_checks++; if (stat_count !== 32'(exp_c[i])) begin n_fail++; $display("FAIL stat_user%0d got %0d exp %0d", users[i], stat_count, exp_c[i]); end
    end
    idle();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 249) == 0);
      s_axis_tvalid = $urandom_range(0, 1); s_axis_tready = $urandom_range(0, 1); s_axis_tlast = ($urandom_range(0, 2) == 0);
      eng_tuple_valid = ($urandom_range(0, 2) == 0); eng_tuple_data = rand_tuple(8'($urandom_range(0, 5)));
      eng_digest_valid = $urandom_range(0, 1); eng_digest_data = rand_digest();
      eng_out_tvalid = ($urandom_range(0, 9) < 7); m_axis_tready = ($urandom_range(0, 9) < 7); eng_out_tlast = ($urandom_range(0, 2) == 0);
      stat_user = 8'($urandom_range(0, 6)); #1;
      n_checks++; if (m_axis_tvalid !== (eng_out_tvalid && q.size() > 0)) begin n_fail++; $display("FAIL rnd_tvalid c%0d got %b", c, m_axis_tvalid); end
      n_checks++; if (eng_out_tready !== (m_axis_tready && q.size() > 0)) begin n_fail++; $display("FAIL rnd_tready c%0d got %b", c, eng_out_tready); end
      n_checks++; if (sdnet_tuple_in_valid !== (!m_inpkt && s_axis_tvalid)) begin n_fail++; $display("FAIL rnd_sop c%0d got %b", c, sdnet_tuple_in_valid); end
      n_checks++; if (sdnet_in_tlast !== (s_axis_tlast && s_axis_tvalid)) begin n_fail++; $display("FAIL rnd_last c%0d got %b", c, sdnet_in_tlast); end
      n_checks++; if (tuple_ovf !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf c%0d got %b exp %b", c, tuple_ovf, m_ovf); end
      n_checks++; if (stat_count !== exp_stat) begin n_fail++; $display("FAIL rnd_stat c%0d got %0d exp %0d", c, stat_count, exp_stat); end
      if (q.size() > 0) begin
        n_checks++; if (m_axis_tuser !== q[0]) begin n_fail++; $display("FAIL rnd_tuser c%0d got %h exp %h", c, m_axis_tuser, q[0]); end
      end
      tick();
    end
    rst = 0; idle();
  endtask

  initial begin
    idle();
    model_reset();
    test_reset();
    test_one_beat();
    test_stall();
    test_digest();
    test_no_digest();
    test_overflow();
    test_stats();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
